// File: rtl/addsub_pkg.sv
// Shared constants and FSM state type for the serial add/subtract block.
package addsub_pkg;

  localparam int unsigned NIBBLE = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit combinational adder with carry in/out; the only adder in the datapath.
module nibble_adder
  import addsub_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout
);

  logic [NIBBLE:0] sum;

  // Zero-extend all terms so the carry lands in the top bit.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};
    s    = sum[NIBBLE-1:0];
    cout = sum[NIBBLE];
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Serial WIDTH-bit add/subtract, one nibble per clock, LSB nibble first.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE;
  localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;        // effective operand: b or ~b
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [NIBBLE-1:0] nib_a, nib_b, nib_s;
  logic              nib_c;

  // Select the current nibble of each latched operand.
  always_comb begin
    nib_a = a_q[idx_q*NIBBLE +: NIBBLE];
    nib_b = b_q[idx_q*NIBBLE +: NIBBLE];
  end

  nibble_adder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic: accept start in IDLE/DONE, step one nibble per RUN cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          carry_d = (op == OP_SUB);
          idx_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[idx_q*NIBBLE +: NIBBLE] = nib_s;
        carry_d = nib_c;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = nib_c;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; overflow from the latched operand and result MSBs.
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    result = result_q;
    cout   = cout_q;
    ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_q[WIDTH-1] != a_q[WIDTH-1]);
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed, table-driven bench for serial_addsub_ctrl at WIDTH=16.
module tb_serial_addsub_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full operation: start at a negedge, scramble inputs after the start
  // edge, check busy each RUN cycle, then the results and a one-cycle done.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] res, input logic co, input logic ov);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, " busy/done in RUN"}, 16'({busy, done}), 16'(2'b10));
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, " busy/done at DONE"}, 16'({busy, done}), 16'(2'b01));
    check({tag, " result"}, result, res);
    check({tag, " cout"}, 16'(cout), 16'(co));
    check({tag, " ovf"}, 16'(ovf), 16'(ov));
    @(negedge clk);
    check({tag, " done pulse ends"}, 16'(done), 16'(0));
  endtask

  initial begin
    int dcount;
    logic [W-1:0] dres;

    vecs[0] = '{1'b0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 16'h0F0F, 16'h0101, 16'h1010, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 16'(busy), 16'(0));
    check("reset done", 16'(done), 16'(0));
    check("reset result", result, 16'h0000);
    check("reset cout", 16'(cout), 16'(0));
    check("reset ovf", 16'(ovf), 16'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].co, vecs[i].ov);
    end

    // Start pulse with new operands at edge 2 of a running op must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0100; b = 16'h0200;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 begin start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'h1111; end
    @(posedge clk);
    #1 start = 1'b0;
    dcount = 0; dres = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) begin dcount++; dres = result; end
    end
    check("ignored start done count", 16'(dcount), 16'(1));
    check("ignored start result", dres, 16'h0300);

    // Reset asserted after edge 2 of a running op aborts it at once.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 16'(busy), 16'(0));
    check("abort done", 16'(done), 16'(0));
    check("abort result", result, 16'h0000);
    check("abort cout/ovf", 16'({cout, ovf}), 16'(0));
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort no done", 16'(dcount), 16'(0));
    rst_n = 1'b1;
    run_op("post-reset add", 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);

    // Start held high through DONE chains a second op with no idle cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0010; b = 16'h0020;
    @(posedge clk);
    #1 begin a = 16'h1000; b = 16'h0234; end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b first done", 16'(done), 16'(1));
    check("b2b first result", result, 16'h0030);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b no idle gap", 16'({busy, done}), 16'(2'b10));
    dcount = 0; dres = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) begin dcount++; dres = result; end
    end
    check("b2b second done count", 16'(dcount), 16'(1));
    check("b2b second result", dres, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
